// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, flag indices and sequencer state encodings
// Purpose: constants and helpers shared by alu_8bits and alu_issue_wb.
// Contents: ALU_* opcode constants, FLAG_* bit positions within {ZF,SF,OF,CF},
//           ST_* sequencer states, is_nop() for the undefined opcode range.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  // Bit positions inside the 4-bit {ZF,SF,OF,CF} flag vector.
  localparam int FLAG_ZF = 3;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_CF = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  // Opcodes above SLTU are treated as no-operation.
  function automatic logic is_nop(input logic [3:0] op);
    return op > ALU_SLTU;
  endfunction

endpackage

// File: rtl/alu_8bits.sv
// rtl/alu_8bits.sv - 8-bit combinational ALU with Z/S/O/C flags
// Purpose: computes alu_res from a, b and aluop; flags derived from the result.
// Ports:
//   a, b     in  8  operands (b[2:0] is the shift amount for shifts)
//   aluop    in  4  operation code (alu_pkg ALU_*); undefined codes give 0
//   alu_res  out 8  result
//   ZF/SF    out 1  result zero / result bit 7
//   OF       out 1  signed overflow (ADD/SUB only)
//   CF       out 1  carry out of ADD, borrow of SUB
module alu_8bits
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] aluop,
  output logic [7:0] alu_res,
  output logic       ZF,
  output logic       SF,
  output logic       OF,
  output logic       CF
);

  logic [8:0] sum9;

  always_comb begin
    sum9    = '0;
    alu_res = '0;
    OF      = 1'b0;
    CF      = 1'b0;
    case (aluop)
      ALU_ADD: begin
        sum9    = {1'b0, a} + {1'b0, b};
        alu_res = sum9[7:0];
        CF      = sum9[8];
        OF      = (a[7] == b[7]) && (alu_res[7] != a[7]);
      end
      ALU_SUB: begin
        // bit 8 of the 9-bit difference is the borrow
        sum9    = {1'b0, a} - {1'b0, b};
        alu_res = sum9[7:0];
        CF      = sum9[8];
        OF      = (a[7] != b[7]) && (alu_res[7] != a[7]);
      end
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_NOT:  alu_res = ~a;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLL:  alu_res = a << b[2:0];
      ALU_SRL:  alu_res = a >> b[2:0];
      ALU_SRA:  alu_res = $signed(a) >>> b[2:0];
      ALU_SLT:  alu_res = {7'd0, $signed(a) < $signed(b)};
      ALU_SLTU: alu_res = {7'd0, a < b};
      default:  alu_res = '0;
    endcase
    ZF = (alu_res == 8'h00);
    SF = alu_res[7];
  end

endmodule

// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - issue/execute/writeback sequencer around alu_8bits
// Purpose: accepts one instruction per handshake, reads operands from an NREG x 8 register
//   file, executes on alu_8bits from registered operands, presents the registered result on
//   a valid/ready channel and writes it back to rd on the result handshake.
// Optional feature: ALU_ISSUE_PERF_EN adds parameter PERF_W and port perf_cnt (retired count).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    instruction handshake (ready only in IDLE)
//   in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm   instruction fields
//   out_valid/out_ready  result handshake (valid only in WB)
//   out_res, out_flags   registered result and {ZF,SF,OF,CF}
//   dbg_addr, dbg_data   combinational register-file read port
//   perf_cnt             retired-instruction count (ALU_ISSUE_PERF_EN only)
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int NREG   = 4,
  parameter int REG_AW = 2
`ifdef ALU_ISSUE_PERF_EN
  ,
  parameter int PERF_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [7:0]        in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_res,
  output logic [3:0]        out_flags,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [7:0]        dbg_data
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cnt
`endif
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [7:0]        opa_q, opa_d;
  logic [7:0]        opb_q, opb_d;
  logic [7:0]        out_res_q, out_res_d;
  logic [3:0]        out_flags_q, out_flags_d;
  logic [7:0]        rf_q [NREG];
  logic [7:0]        rf_d [NREG];
`ifdef ALU_ISSUE_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;
`endif

  logic [7:0] alu_res;
  logic       alu_zf, alu_sf, alu_of, alu_cf;

  alu_8bits u_alu (
    .a      (opa_q),
    .b      (opb_q),
    .aluop  (op_q),
    .alu_res(alu_res),
    .ZF     (alu_zf),
    .SF     (alu_sf),
    .OF     (alu_of),
    .CF     (alu_cf)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    out_res_d   = out_res_q;
    out_flags_d = out_flags_q;
    rf_d        = rf_q;
`ifdef ALU_ISSUE_PERF_EN
    perf_d      = perf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          opa_d   = rf_q[in_rs1];
          opb_d   = in_use_imm ? in_imm : rf_q[in_rs2];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_nop(op_q)) begin
          // NOP leaves the previous flags visible
          out_res_d = 8'h00;
        end else begin
          out_res_d              = alu_res;
          out_flags_d[FLAG_ZF]   = alu_zf;
          out_flags_d[FLAG_SF]   = alu_sf;
          out_flags_d[FLAG_OF]   = alu_of;
          out_flags_d[FLAG_CF]   = alu_cf;
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        if (out_ready) begin
          if (!is_nop(op_q)) begin
            rf_d[rd_q] = out_res_q;
          end
`ifdef ALU_ISSUE_PERF_EN
          perf_d = perf_q + 1'b1;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      out_res_q   <= '0;
      out_flags_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
`ifdef ALU_ISSUE_PERF_EN
      perf_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
      rf_q        <= rf_d;
`ifdef ALU_ISSUE_PERF_EN
      perf_q      <= perf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_WB);
  assign out_res   = out_res_q;
  assign out_flags = out_flags_q;
  assign dbg_data  = rf_q[dbg_addr];
`ifdef ALU_ISSUE_PERF_EN
  assign perf_cnt  = perf_q;
`endif

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - self-checking bench for alu_issue_wb
module tb_alu_issue_wb;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd, in_rs1, in_rs2;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [3:0] out_flags;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_wb #(.NREG(4), .REG_AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_use_imm(in_use_imm),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU: returns {flags, result} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] old_flags);
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb = $signed(b);
    int r  = 0;
    int sr = 0;
    logic [7:0] res;
    logic o = 1'b0;
    logic c = 1'b0;
    case (op)
      4'd0:  begin r = ua + ub; sr = sa + sb; c = (r > 255); o = (sr > 127) || (sr < -128); end
      4'd1:  begin r = ua - ub; sr = sa - sb; c = (ua < ub); o = (sr > 127) || (sr < -128); end
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = 255 - ua;
      4'd5:  r = ua ^ ub;
      4'd6:  r = ua << (ub % 8);
      4'd7:  r = ua >> (ub % 8);
      4'd8:  r = sa >>> (ub % 8);
      4'd9:  r = (sa < sb) ? 1 : 0;
      4'd10: r = (ua < ub) ? 1 : 0;
      default: return {old_flags, 8'h00};
    endcase
    res = r[7:0];
    return {(res == 8'h00), res[7], o, c, res};
  endfunction

  // Transaction-level model: an instruction is pending from acceptance until its
  // result handshake; its result becomes visible one edge after acceptance.
  logic [7:0] m_rf [4];
  bit         m_pending = 0;
  bit         m_shown = 0;
  logic [7:0] m_res = 0, m_nres = 0;
  logic [3:0] m_flags = 0, m_nflags = 0;
  logic [1:0] m_rd = 0;
  bit         m_nop = 0;
  int         m_perf = 0;
  bit         chk_en = 0;

  always @(posedge clk) begin
    logic [11:0] r;
    logic [7:0]  b;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_pending = 0; m_shown = 0; m_res = 0; m_flags = 0; m_perf = 0;
      chk_en = 1;
    end else if (m_pending) begin
      if (!m_shown) begin
        m_shown = 1;
        m_res   = m_nres;
        m_flags = m_nflags;
      end else if (out_ready) begin
        if (!m_nop) m_rf[m_rd] = m_res;
        m_perf++;
        m_pending = 0;
      end
    end else if (in_valid) begin
      b = in_use_imm ? in_imm : m_rf[in_rs2];
      r = ref_alu(in_op, m_rf[in_rs1], b, m_flags);
      m_nres = r[7:0]; m_nflags = r[11:8];
      m_rd = in_rd; m_nop = (in_op > 4'd10);
      m_pending = 1; m_shown = 0;
    end
  end

  always @(posedge clk) begin
    #4;
    if (chk_en) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_pending));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_pending && m_shown));
      chk("cyc_out_res", 32'(out_res), 32'(m_res));
      chk("cyc_out_flags", 32'(out_flags), 32'(m_flags));
      chk("cyc_dbg_data", 32'(dbg_data), 32'(m_rf[dbg_addr]));
`ifdef ALU_ISSUE_PERF_EN
      chk("cyc_perf_cnt", 32'(perf_cnt), 32'(m_perf % 65536));
`endif
    end
  end

  // Issue one instruction from an idle negedge and complete it, stalling the result
  // handshake for 'stall' cycles. Returns at a negedge with the DUT idle again.
  task automatic run_instr(input string name, input logic [3:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic use_imm,
                           input logic [7:0] imm, input int stall,
                           input logic [7:0] exp_res, input logic [3:0] exp_flags);
    int lat;
    in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = use_imm; in_imm = imm;
    out_ready = (stall == 0);
    @(posedge clk); @(negedge clk);
    in_valid = 0; in_op = ~op; in_rd = ~rd; in_rs1 = ~rs1; in_imm = ~imm;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd2);
    chk({name, "_res"}, 32'(out_res), 32'(exp_res));
    chk({name, "_flags"}, 32'(out_flags), 32'(exp_flags));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      chk({name, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_stall_res"}, 32'(out_res), 32'(exp_res));
      chk({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    @(posedge clk); @(negedge clk);
    chk({name, "_done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int acc;
    rst = 1; in_valid = 0; in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_use_imm = 0; in_imm = 0; out_ready = 1; dbg_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_res", 32'(out_res), 32'd0);
    chk("reset_flags", 32'(out_flags), 32'd0);

    // basic add, then signed overflow, then zero result
    dbg_addr = 2'd1;
    run_instr("add_imm", 4'd0, 2'd1, 2'd0, 2'd0, 1, 8'h78, 0, 8'h78, 4'b0000);
    chk("add_imm_wb", 32'(dbg_data), 32'h78);
    dbg_addr = 2'd2;
    run_instr("add_ovf", 4'd0, 2'd2, 2'd1, 2'd0, 1, 8'h08, 0, 8'h80, 4'b0110);
    chk("add_ovf_wb", 32'(dbg_data), 32'h80);
    dbg_addr = 2'd3;
    run_instr("sub_zero", 4'd1, 2'd3, 2'd2, 2'd2, 0, 8'h00, 0, 8'h00, 4'b1000);
    chk("sub_zero_wb", 32'(dbg_data), 32'h00);

    // NOP keeps flags, writes nothing (R0 stays 0)
    dbg_addr = 2'd0;
    run_instr("nop", 4'hF, 2'd0, 2'd1, 2'd1, 1, 8'h55, 0, 8'h00, 4'b1000);
    chk("nop_no_wb", 32'(dbg_data), 32'h00);

    // back-pressure for 3 cycles; R0 must not change until the handshake
    run_instr("xor_stall", 4'd5, 2'd0, 2'd1, 2'd0, 1, 8'hFF, 3, 8'h87, 4'b0100);
    chk("xor_stall_wb", 32'(dbg_data), 32'h87);

    // R0=87 R1=78 R2=80 R3=00
    dbg_addr = 2'd3;
    run_instr("sub_borrow", 4'd1, 2'd3, 2'd1, 2'd2, 0, 8'h00, 0, 8'hF8, 4'b0111);
    run_instr("sra",  4'd8,  2'd3, 2'd2, 2'd0, 1, 8'h03, 0, 8'hF0, 4'b0100);
    run_instr("srl",  4'd7,  2'd3, 2'd2, 2'd0, 1, 8'h03, 0, 8'h10, 4'b0000);
    run_instr("sll",  4'd6,  2'd3, 2'd1, 2'd0, 1, 8'h01, 0, 8'hF0, 4'b0100);
    run_instr("slt",  4'd9,  2'd3, 2'd2, 2'd1, 0, 8'h00, 0, 8'h01, 4'b0000);
    run_instr("sltu", 4'd10, 2'd3, 2'd2, 2'd1, 0, 8'h00, 0, 8'h00, 4'b1000);
    run_instr("not",  4'd4,  2'd3, 2'd1, 2'd0, 0, 8'h00, 0, 8'h87, 4'b0100);
    run_instr("and",  4'd2,  2'd3, 2'd0, 2'd0, 1, 8'h0F, 0, 8'h07, 4'b0000);
    run_instr("or",   4'd3,  2'd3, 2'd0, 2'd0, 1, 8'h70, 0, 8'hF7, 4'b0100);
    run_instr("add_carry", 4'd0, 2'd3, 2'd0, 2'd2, 0, 8'h00, 0, 8'h07, 4'b0011);
    // read-after-write through R0
    run_instr("add_raw1", 4'd0, 2'd0, 2'd0, 2'd0, 0, 8'h00, 0, 8'h0E, 4'b0011);
    run_instr("add_raw2", 4'd0, 2'd1, 2'd0, 2'd0, 1, 8'h00, 0, 8'h0E, 4'b0000);

    // reset during EXEC drops the instruction
    dbg_addr = 2'd1;
    in_valid = 1; in_op = 4'd0; in_rd = 2'd1; in_rs1 = 2'd0; in_use_imm = 1; in_imm = 8'h05;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    chk("rst_exec_busy", 32'(in_ready), 32'd0);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    #1;
    chk("rst_exec_in_ready", 32'(in_ready), 32'd1);
    chk("rst_exec_out_valid", 32'(out_valid), 32'd0);
    chk("rst_exec_r1", 32'(dbg_data), 32'h00);
    chk("rst_exec_flags", 32'(out_flags), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("rst_exec_perf", 32'(perf_cnt), 32'd0);
`endif
    @(posedge clk); @(negedge clk);
    chk("rst_exec_stays_idle", 32'(out_valid), 32'd0);

    // in_valid held high with changing fields: one accept per 3 cycles
    acc = 0;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1;
      in_op = 4'($urandom_range(0, 15));
      in_rd = 2'($urandom_range(0, 3));
      in_rs1 = 2'($urandom_range(0, 3));
      in_rs2 = 2'($urandom_range(0, 3));
      in_use_imm = 1'($urandom_range(0, 1));
      in_imm = 8'($urandom_range(0, 255));
      dbg_addr = 2'(i);
      #1;
      if (in_ready) acc++;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 0;
    chk("held_valid_accepts", 32'(acc), 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("held_valid_idle", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
